dac_tx_frontend: RTL and testbench

DAC_TX_FRONTEND -- requirements
Module: dac_tx_frontend

---
 rtl/tx_frontend_pkg.sv | 17 +
 rtl/dac_tx_frontend_if.sv | 25 ++
 rtl/iq_gain_scale.sv | 27 ++
 rtl/dac_tx_frontend.sv | 143 ++++++++++++++
 tb/tb_dac_tx_frontend.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/tx_frontend_pkg.sv
// Shared types and constants for the DAC transmit front end:
// FSM state encoding, sample width and the default ramp length.
package tx_frontend_pkg;

  localparam int SAMPLE_W          = 12;
  localparam int RAMP_LOG2_DEFAULT = 4;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } tx_state_e;

endpackage

// File: rtl/dac_tx_frontend_if.sv
// Modulator-side sample bus and DAC-side status bundle for dac_tx_frontend.
// The master drives samples and burst enable; the slave returns DAC words and status.
interface dac_tx_frontend_if;

  tx_frontend_pkg::sample_t dac_i;
  tx_frontend_pkg::sample_t dac_q;
  logic                     dac_valid;
  logic                     tx_en;
  logic [11:0]              dac_data;
  logic                     dac_frame;
  logic                     tx_active;
  logic                     ramp_busy;
  logic [15:0]              underflow_cnt;

  modport master (
    output dac_i, dac_q, dac_valid, tx_en,
    input  dac_data, dac_frame, tx_active, ramp_busy, underflow_cnt
  );

  modport slave (
    input  dac_i, dac_q, dac_valid, tx_en,
    output dac_data, dac_frame, tx_active, ramp_busy, underflow_cnt
  );

endinterface

// File: rtl/iq_gain_scale.sv
// Applies ramp gain k/2^RAMP_LOG2 to one signed sample: floor((s * k) / 2^RAMP_LOG2).
// k = 2^RAMP_LOG2 reproduces the sample exactly.
module iq_gain_scale
  import tx_frontend_pkg::*;
#(
  parameter int RAMP_LOG2 = RAMP_LOG2_DEFAULT
) (
  input  sample_t              sample_i,
  input  logic [RAMP_LOG2:0]   gain_i,
  output sample_t              scaled_o
);

  // One spare bit over the 12 x (RAMP_LOG2+1) product keeps the gain operand non-negative.
  localparam int PROD_W = SAMPLE_W + RAMP_LOG2 + 2;

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] prod;

  assign sample_ext = {{(PROD_W-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i};
  assign gain_ext   = {{(PROD_W-RAMP_LOG2-1){1'b0}}, gain_i};
  assign prod       = sample_ext * gain_ext;

  // Arithmetic shift floors toward negative infinity.
  assign scaled_o = sample_t'(prod >>> RAMP_LOG2);

endmodule

// File: rtl/dac_tx_frontend.sv
// Burst ramp controller and I/Q interleaver in front of a single 12-bit DAC.
// Samples arrive at half rate (clk_16M384 enable); I and Q leave on alternate cycles.
module dac_tx_frontend
  import tx_frontend_pkg::*;
#(
  parameter int RAMP_LOG2     = RAMP_LOG2_DEFAULT,
  parameter bit OFFSET_BINARY = 1'b0
) (
  input  logic                clk_32M768,
  input  logic                rst_n_32M768,
  input  logic                clk_16M384,
  input  sample_t             DAC_I,
  input  sample_t             DAC_Q,
  input  logic                DAC_valid,
  input  logic                TX_EN,
  output logic [SAMPLE_W-1:0] dac_data,
  output logic                dac_frame,
  output logic                tx_active,
  output logic                ramp_busy,
  output logic [15:0]         underflow_cnt
);

  localparam logic [RAMP_LOG2:0]  K_FULL   = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [SAMPLE_W-1:0] MSB_FLIP = {OFFSET_BINARY, {(SAMPLE_W-1){1'b0}}};

  tx_state_e          state_q, state_d;
  logic [RAMP_LOG2:0] k_q, k_d;
  sample_t            hold_i_q, hold_i_d;
  sample_t            hold_q_q, hold_q_d;
  logic [15:0]        uf_cnt_q, uf_cnt_d;
  sample_t            q_word_q;
  logic [SAMPLE_W-1:0] dac_data_q;
  logic               dac_frame_q;

  sample_t            samp_i, samp_q, scaled_i, scaled_q;
  logic [RAMP_LOG2:0] gain;

  always_comb begin
    // NOTE: every *_d takes its current value first, so no branch can infer a latch.
    state_d  = state_q;
    k_d      = k_q;
    hold_i_d = hold_i_q;
    hold_q_d = hold_q_q;
    uf_cnt_d = uf_cnt_q;
    if (clk_16M384) begin
      if (DAC_valid) begin
        hold_i_d = DAC_I;
        hold_q_d = DAC_Q;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (TX_EN && DAC_valid) begin
            state_d = ST_RAMP_UP;
            k_d     = '0;
          end
        end
        ST_RAMP_UP: begin
          if (!TX_EN) begin
            state_d = ST_RAMP_DOWN;
          end else if (DAC_valid) begin
            k_d = k_q + 1'b1;
            if (k_d == K_FULL) state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (!TX_EN) begin
            state_d = ST_RAMP_DOWN;
          end else if (!DAC_valid) begin
            state_d = ST_RAMP_DOWN;
            if (uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
          end
        end
        ST_RAMP_DOWN: begin
          // TX_EN is ignored here: a new burst only starts from IDLE.
          if (k_q[RAMP_LOG2:1] == '0) begin
            k_d     = '0;
            state_d = ST_IDLE;
          end else begin
            k_d = k_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A missing sample repeats the last valid one; IDLE forces zero gain.
  assign samp_i = DAC_valid ? DAC_I : hold_i_q;
  assign samp_q = DAC_valid ? DAC_Q : hold_q_q;
  assign gain   = (state_q == ST_IDLE) ? '0 : k_q;

  iq_gain_scale #(.RAMP_LOG2(RAMP_LOG2)) u_scale_i (
    .sample_i (samp_i),
    .gain_i   (gain),
    .scaled_o (scaled_i)
  );

  iq_gain_scale #(.RAMP_LOG2(RAMP_LOG2)) u_scale_q (
    .sample_i (samp_q),
    .gain_i   (gain),
    .scaled_o (scaled_q)
  );

  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      hold_i_q <= '0;
      hold_q_q <= '0;
      uf_cnt_q <= '0;
    end else begin
      // NOTE: registers use <= so every one updates from the same pre-edge values.
      state_q  <= state_d;
      k_q      <= k_d;
      hold_i_q <= hold_i_d;
      hold_q_q <= hold_q_d;
      uf_cnt_q <= uf_cnt_d;
    end
  end

  // I leaves on the enable edge, Q on the following edge; back-to-back enables drop Q.
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      dac_data_q  <= MSB_FLIP;
      dac_frame_q <= 1'b0;
      q_word_q    <= '0;
    end else if (clk_16M384) begin
      dac_data_q  <= scaled_i ^ MSB_FLIP;
      dac_frame_q <= 1'b1;
      q_word_q    <= scaled_q;
    end else begin
      dac_data_q  <= q_word_q ^ MSB_FLIP;
      dac_frame_q <= 1'b0;
    end
  end

  assign dac_data      = dac_data_q;
  assign dac_frame     = dac_frame_q;
  assign tx_active     = (state_q != ST_IDLE);
  assign ramp_busy     = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
  assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_dac_tx_frontend.sv
// Directed bench for dac_tx_frontend: table of ramp/underflow vectors plus
// hand-written abort, arithmetic and mid-burst reset sequences.
module tb_dac_tx_frontend;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;

  always #5 clk = ~clk;

  dac_tx_frontend_if bus ();

  logic [11:0] dac_data_ob;
  logic        dac_frame_ob, tx_active_ob, ramp_busy_ob;
  logic [15:0] underflow_cnt_ob;

  dac_tx_frontend dut (
    .clk_32M768    (clk),
    .rst_n_32M768  (rst_n),
    .clk_16M384    (ce),
    .DAC_I         (bus.dac_i),
    .DAC_Q         (bus.dac_q),
    .DAC_valid     (bus.dac_valid),
    .TX_EN         (bus.tx_en),
    .dac_data      (bus.dac_data),
    .dac_frame     (bus.dac_frame),
    .tx_active     (bus.tx_active),
    .ramp_busy     (bus.ramp_busy),
    .underflow_cnt (bus.underflow_cnt)
  );

  dac_tx_frontend #(.OFFSET_BINARY(1'b1)) dut_ob (
    .clk_32M768    (clk),
    .rst_n_32M768  (rst_n),
    .clk_16M384    (ce),
    .DAC_I         (bus.dac_i),
    .DAC_Q         (bus.dac_q),
    .DAC_valid     (bus.dac_valid),
    .TX_EN         (bus.tx_en),
    .dac_data      (dac_data_ob),
    .dac_frame     (dac_frame_ob),
    .tx_active     (tx_active_ob),
    .ramp_busy     (ramp_busy_ob),
    .underflow_cnt (underflow_cnt_ob)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [11:0] got_i, got_q, got_oi;
  logic        got_fi, got_fq;

  typedef struct {
    logic [11:0] i;
    logic [11:0] q;
    logic        v;
    logic        en;
    logic [11:0] exp_i;
    logic [11:0] exp_q;
    logic        exp_act;
    logic        exp_busy;
    logic [15:0] exp_uf;
  } vec_t;

  vec_t vec[36];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // One sample period: enable cycle (I word captured) then non-enable cycle (Q word).
  task automatic step(input logic [11:0] i, input logic [11:0] q, input logic v, input logic en);
    @(negedge clk);
    ce = 1'b1;
    bus.dac_i = i;
    bus.dac_q = q;
    bus.dac_valid = v;
    bus.tx_en = en;
    @(posedge clk);
    #1;
    got_i  = bus.dac_data;
    got_fi = bus.dac_frame;
    got_oi = dac_data_ob;
    @(negedge clk);
    ce = 1'b0;
    @(posedge clk);
    #1;
    got_q  = bus.dac_data;
    got_fq = bus.dac_frame;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    ce = 1'b0;
    bus.dac_i = '0;
    bus.dac_q = '0;
    bus.dac_valid = 1'b0;
    bus.tx_en = 1'b0;

    // Ramp up 0..15, ACTIVE at full gain, underflow, ramp down 16..1, IDLE.
    vec[0] = '{12'h400, 12'hC00, 1'b1, 1'b1, 12'h000, 12'h000, 1'b1, 1'b1, 16'd0};
    for (int j = 1; j <= 16; j++) begin
      k = j - 1;
      vec[j] = '{12'h400, 12'hC00, 1'b1, 1'b1, 12'(k * 64), 12'(-(k * 64)),
                 1'b1, (j < 16), 16'd0};
    end
    vec[17] = '{12'h400, 12'hC00, 1'b1, 1'b1, 12'h400, 12'hC00, 1'b1, 1'b0, 16'd0};
    vec[18] = '{12'h123, 12'h321, 1'b0, 1'b1, 12'h400, 12'hC00, 1'b1, 1'b1, 16'd1};
    for (int m = 0; m < 16; m++) begin
      k = 16 - m;
      if (m >= 6 && m <= 11)
        vec[19+m] = '{12'h400, 12'hC00, 1'b1, 1'b1, 12'(k * 64), 12'(-(k * 64)),
                      (m < 15), (m < 15), 16'd1};
      else
        vec[19+m] = '{12'h123, 12'h321, 1'b0, 1'b0, 12'(k * 64), 12'(-(k * 64)),
                      (m < 15), (m < 15), 16'd1};
    end
    vec[35] = '{12'h400, 12'hC00, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 16'd1};

    repeat (3) @(posedge clk);
    #1;
    check("rst dac_data", bus.dac_data, 12'h000);
    check("rst dac_frame", bus.dac_frame, 1'b0);
    check("rst tx_active", bus.tx_active, 1'b0);
    check("rst ramp_busy", bus.ramp_busy, 1'b0);
    check("rst underflow_cnt", bus.underflow_cnt, 16'd0);
    check("rst offset dac_data", dac_data_ob, 12'h800);
    @(negedge clk);
    rst_n = 1'b1;

    for (int j = 0; j < 36; j++) begin
      step(vec[j].i, vec[j].q, vec[j].v, vec[j].en);
      check($sformatf("vec%0d I word", j), got_i, vec[j].exp_i);
      check($sformatf("vec%0d Q word", j), got_q, vec[j].exp_q);
      check($sformatf("vec%0d frame I", j), got_fi, 1'b1);
      check($sformatf("vec%0d frame Q", j), got_fq, 1'b0);
      check($sformatf("vec%0d offset I", j), got_oi, vec[j].exp_i ^ 12'h800);
      check($sformatf("vec%0d tx_active", j), bus.tx_active, vec[j].exp_act);
      check($sformatf("vec%0d ramp_busy", j), bus.ramp_busy, vec[j].exp_busy);
      check($sformatf("vec%0d underflow", j), bus.underflow_cnt, vec[j].exp_uf);
    end

    // Abort at k=5: five decrements back to IDLE, underflow count untouched.
    step(12'h400, 12'hC00, 1'b1, 1'b1);
    repeat (5) step(12'h400, 12'hC00, 1'b1, 1'b1);
    step(12'h400, 12'hC00, 1'b1, 1'b0);
    check("abort I word k5", got_i, 12'h140);
    check("abort Q word k5", got_q, 12'hEC0);
    check("abort ramp_busy", bus.ramp_busy, 1'b1);
    step(12'h000, 12'h000, 1'b0, 1'b0);
    check("abort down I k5", got_i, 12'h140);
    step(12'h000, 12'h000, 1'b0, 1'b0);
    check("abort down I k4", got_i, 12'h100);
    step(12'h000, 12'h000, 1'b0, 1'b0);
    step(12'h000, 12'h000, 1'b0, 1'b1);
    check("abort down I k2", got_i, 12'h080);
    check("abort active before end", bus.tx_active, 1'b1);
    step(12'h000, 12'h000, 1'b0, 1'b0);
    check("abort down I k1", got_i, 12'h040);
    check("abort idle", bus.tx_active, 1'b0);
    check("abort underflow", bus.underflow_cnt, 16'd1);

    // Floor arithmetic: -2047/16 -> -128, 2047/16 -> 127; full gain is exact.
    step(12'h801, 12'h7FF, 1'b1, 1'b1);
    step(12'h801, 12'h7FF, 1'b1, 1'b1);
    check("arith I k0", got_i, 12'h000);
    step(12'h801, 12'h7FF, 1'b1, 1'b1);
    check("arith I k1", got_i, 12'hF80);
    check("arith Q k1", got_q, 12'h07F);
    check("arith offset I k1", got_oi, 12'h780);
    repeat (14) step(12'h801, 12'h7FF, 1'b1, 1'b1);
    check("arith active", bus.tx_active, 1'b1);
    check("arith not busy", bus.ramp_busy, 1'b0);
    step(12'h801, 12'h7FF, 1'b1, 1'b1);
    check("arith I k16", got_i, 12'h801);
    check("arith Q k16", got_q, 12'h7FF);
    check("arith offset I k16", got_oi, 12'h001);

    // Asynchronous reset while ACTIVE, right after an I word.
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk);
    #1;
    check("pre-reset frame", bus.dac_frame, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async rst dac_data", bus.dac_data, 12'h000);
    check("async rst dac_frame", bus.dac_frame, 1'b0);
    check("async rst tx_active", bus.tx_active, 1'b0);
    check("async rst ramp_busy", bus.ramp_busy, 1'b0);
    check("async rst underflow", bus.underflow_cnt, 16'd0);
    check("async rst offset data", dac_data_ob, 12'h800);
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(12'h400, 12'hC00, 1'b0, 1'b1);
    check("post-rst idle en only", bus.tx_active, 1'b0);
    step(12'h400, 12'hC00, 1'b1, 1'b0);
    check("post-rst idle valid only", bus.tx_active, 1'b0);
    check("post-rst idle word", got_i, 12'h000);
    step(12'h400, 12'hC00, 1'b1, 1'b1);
    check("post-rst start", bus.tx_active, 1'b1);
    check("post-rst busy", bus.ramp_busy, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
